// File: rtl/seq_pipeline_controller_if.sv
// Pipeline hazard/halt control bundle between the pipeline stages and the
// sequencing controller. The stage side (master) drives the events; the
// controller (slave) returns the stall/flush/halt controls and status.
interface seq_pipeline_controller_if #(
    parameter int MC_CNT_WIDTH = 4,
    parameter int STAT_WIDTH   = 16
);
    // Events raised by the pipeline stages
    logic                    i_halt_instr;
    logic                    i_resume;
    logic                    i_branch_taken;
    logic                    i_mc_start;
    logic [MC_CNT_WIDTH-1:0] i_mc_cycles;
    logic                    i_load_use;
    logic                    i_clr_stats;

    // Controls and status returned by the controller
    logic                    o_front_halt;
    logic                    o_decode_bubble;
    logic                    o_flush;
    logic                    o_sys_halt;
    logic                    o_halted;
    logic [1:0]              o_state;
    logic [STAT_WIDTH-1:0]   o_stall_cycles;

    modport master (
        output i_halt_instr, i_resume, i_branch_taken, i_mc_start,
               i_mc_cycles, i_load_use, i_clr_stats,
        input  o_front_halt, o_decode_bubble, o_flush, o_sys_halt,
               o_halted, o_state, o_stall_cycles
    );

    modport slave (
        input  i_halt_instr, i_resume, i_branch_taken, i_mc_start,
               i_mc_cycles, i_load_use, i_clr_stats,
        output o_front_halt, o_decode_bubble, o_flush, o_sys_halt,
               o_halted, o_state, o_stall_cycles
    );
endinterface

// File: rtl/seq_pipeline_controller.sv
// Sequencing controller for an in-order pipeline: resolves branch flushes,
// multi-cycle execute stalls, HALT instructions and load-use bubbles, and
// counts front-end stall cycles. Event priority in RUN is
// branch > multi-cycle start > halt > load-use.
// There is no valid/ready handshake here: every event input is a level
// sampled each cycle and the control outputs are combinational from the
// current state and those inputs, so the stages see them in the same cycle.
module seq_pipeline_controller #(
    parameter int MC_CNT_WIDTH = 4,
    parameter int STAT_WIDTH   = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    seq_pipeline_controller_if.slave ctl
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MC_WAIT = 2'd1,
        ST_HALTED  = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [MC_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                    pend_q, pend_d;
    logic [STAT_WIDTH-1:0]   stats_q;

    logic front_halt, decode_bubble, flush, sys_halt, halted;

    // State, multi-cycle down-counter and pending-halt flag registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state and control decode; the counter holds remaining wait
    // cycles minus one, so the cycle it reads zero is the last MC_WAIT cycle
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pend_d        = pend_q;
        front_halt    = 1'b0;
        decode_bubble = 1'b0;
        flush         = 1'b0;
        sys_halt      = 1'b0;
        halted        = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (ctl.i_branch_taken) begin
                    flush = 1'b1;
                end else if (ctl.i_mc_start &&
                             (ctl.i_mc_cycles > MC_CNT_WIDTH'(1))) begin
                    front_halt = 1'b1;
                    state_d    = ST_MC_WAIT;
                    cnt_d      = ctl.i_mc_cycles - MC_CNT_WIDTH'(2);
                    pend_d     = ctl.i_halt_instr;
                end else if (ctl.i_halt_instr) begin
                    front_halt    = 1'b1;
                    decode_bubble = 1'b1;
                    state_d       = ST_HALTED;
                    pend_d        = 1'b0;
                end else if (ctl.i_load_use) begin
                    front_halt    = 1'b1;
                    decode_bubble = 1'b1;
                end
            end
            ST_MC_WAIT: begin
                front_halt = 1'b1;
                sys_halt   = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - MC_CNT_WIDTH'(1);
                end else if (pend_q) begin
                    state_d = ST_HALTED;
                    pend_d  = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                front_halt = 1'b1;
                sys_halt   = 1'b1;
                halted     = 1'b1;
                pend_d     = 1'b0;
                if (ctl.i_resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                // Unreachable encoding: all controls idle, recover to RUN
                state_d = ST_RUN;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    // Saturating count of front-end stall cycles; clear beats increment
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stats_q <= '0;
        end else if (ctl.i_clr_stats) begin
            stats_q <= '0;
        end else if (front_halt && (stats_q != {STAT_WIDTH{1'b1}})) begin
            stats_q <= stats_q + STAT_WIDTH'(1);
        end
    end

    assign ctl.o_front_halt    = front_halt;
    assign ctl.o_decode_bubble = decode_bubble;
    assign ctl.o_flush         = flush;
    assign ctl.o_sys_halt      = sys_halt;
    assign ctl.o_halted        = halted;
    assign ctl.o_state         = state_q;
    assign ctl.o_stall_cycles  = stats_q;

endmodule

// File: tb/tb_seq_pipeline_controller.sv
// Bench for seq_pipeline_controller: directed scenarios with literal
// expectations, then randomized events, all checked every cycle against a
// behavioural model of the controller.
module tb_seq_pipeline_controller;

    localparam int MC_W     = 4;
    localparam int STAT_W   = 4;
    localparam int STAT_MAX = (1 << STAT_W) - 1;

    logic clk;
    logic rst_n;

    int n_cmp = 0;
    int n_err = 0;

    seq_pipeline_controller_if #(.MC_CNT_WIDTH(MC_W), .STAT_WIDTH(STAT_W)) bus ();

    seq_pipeline_controller #(.MC_CNT_WIDTH(MC_W), .STAT_WIDTH(STAT_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .ctl     (bus.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- comparison helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // exp_q holds the o_state value of each remaining multi-cycle wait cycle;
    // while it is non-empty the controller is waiting.
    logic [1:0] exp_q[$];
    bit         m_halted;
    bit         m_halt_after;
    int         m_stalls;

    initial begin
        m_halted     = 0;
        m_halt_after = 0;
        m_stalls     = 0;
    end

    // Compare process: checks every output each cycle, then advances the model
    always @(negedge clk) begin
        bit   e_fh, e_bub, e_fl, e_sh, e_hal;
        int   e_state;
        if (!rst_n) begin
            exp_q.delete();
            m_halted     = 0;
            m_halt_after = 0;
            m_stalls     = 0;
        end
        e_fh = 0; e_bub = 0; e_fl = 0; e_sh = 0; e_hal = 0; e_state = 0;
        if (exp_q.size() != 0) begin
            e_state = int'(exp_q[0]);
            e_fh = 1; e_sh = 1;
        end else if (m_halted) begin
            e_state = 2;
            e_fh = 1; e_sh = 1; e_hal = 1;
        end else begin
            e_state = 0;
            if (bus.i_branch_taken)
                e_fl = 1;
            else if (bus.i_mc_start && int'(bus.i_mc_cycles) >= 2)
                e_fh = 1;
            else if (bus.i_halt_instr || bus.i_load_use) begin
                e_fh = 1; e_bub = 1;
            end
        end

        chk("front_halt",    32'(bus.o_front_halt),    32'(e_fh));
        chk("decode_bubble", 32'(bus.o_decode_bubble), 32'(e_bub));
        chk("flush",         32'(bus.o_flush),         32'(e_fl));
        chk("sys_halt",      32'(bus.o_sys_halt),      32'(e_sh));
        chk("halted",        32'(bus.o_halted),        32'(e_hal));
        chk("state",         32'(bus.o_state),         32'(e_state));
        chk("stall_cycles",  32'(bus.o_stall_cycles),  32'(m_stalls));

        if (rst_n) begin
            if (bus.i_clr_stats)
                m_stalls = 0;
            else if (e_fh && m_stalls < STAT_MAX)
                m_stalls = m_stalls + 1;

            if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0 && m_halt_after) begin
                    m_halted     = 1;
                    m_halt_after = 0;
                end
            end else if (m_halted) begin
                if (bus.i_resume) m_halted = 0;
            end else if (!bus.i_branch_taken) begin
                if (bus.i_mc_start && int'(bus.i_mc_cycles) >= 2) begin
                    for (int k = 0; k < int'(bus.i_mc_cycles) - 1; k++)
                        exp_q.push_back(2'd1);
                    m_halt_after = bus.i_halt_instr;
                end else if (bus.i_halt_instr) begin
                    m_halted = 1;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input bit rst, input bit br, input bit mc, input int cyc,
                        input bit hlt, input bit lu, input bit rs, input bit clr);
        @(posedge clk);
        #1;
        rst_n              = rst;
        bus.i_branch_taken = br;
        bus.i_mc_start     = mc;
        bus.i_mc_cycles    = MC_W'(cyc);
        bus.i_halt_instr   = hlt;
        bus.i_load_use     = lu;
        bus.i_resume       = rs;
        bus.i_clr_stats    = clr;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.i_branch_taken = 1'b0;
        bus.i_mc_start     = 1'b0;
        bus.i_mc_cycles    = '0;
        bus.i_halt_instr   = 1'b0;
        bus.i_load_use     = 1'b0;
        bus.i_resume       = 1'b0;
        bus.i_clr_stats    = 1'b0;

        // Reset state
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_rst_state",  32'(bus.o_state),        32'd0);
        chk("lit_rst_stats",  32'(bus.o_stall_cycles), 32'd0);
        chk("lit_rst_halted", 32'(bus.o_halted),       32'd0);
        chk("lit_rst_sysh",   32'(bus.o_sys_halt),     32'd0);

        // Single load-use bubble
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1, 0, 0);
        chk("lit_lu_fh",  32'(bus.o_front_halt),    32'd1);
        chk("lit_lu_bub", 32'(bus.o_decode_bubble), 32'd1);
        idle();
        chk("lit_lu_fh_after", 32'(bus.o_front_halt),   32'd0);
        chk("lit_lu_stats",    32'(bus.o_stall_cycles), 32'd1);

        // Four-cycle operation
        step(1, 0, 1, 4, 0, 0, 0, 0);
        chk("lit_mc4_fh0", 32'(bus.o_front_halt), 32'd1);
        chk("lit_mc4_sh0", 32'(bus.o_sys_halt),   32'd0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("lit_mc4_state", 32'(bus.o_state),    32'd1);
            chk("lit_mc4_sh",    32'(bus.o_sys_halt), 32'd1);
        end
        idle();
        chk("lit_mc4_done",  32'(bus.o_state),        32'd0);
        chk("lit_mc4_stats", 32'(bus.o_stall_cycles), 32'd5);

        // Branch beats halt and load-use
        step(1, 1, 0, 0, 1, 1, 0, 0);
        chk("lit_br_flush", 32'(bus.o_flush),      32'd1);
        chk("lit_br_fh",    32'(bus.o_front_halt), 32'd0);
        idle();
        chk("lit_br_state", 32'(bus.o_state), 32'd0);

        // Multi-cycle with pending halt, resume ignored while waiting
        step(1, 0, 1, 3, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        chk("lit_mch_w1", 32'(bus.o_state), 32'd1);
        idle();
        chk("lit_mch_w2", 32'(bus.o_state), 32'd1);
        idle();
        chk("lit_mch_halted", 32'(bus.o_halted), 32'd1);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        chk("lit_mch_still", 32'(bus.o_state), 32'd2);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        chk("lit_mch_run", 32'(bus.o_state), 32'd0);
        idle();
        chk("lit_resume_in_run", 32'(bus.o_state), 32'd0);

        // Stall counter saturation and clear
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        chk("lit_halt_bub", 32'(bus.o_decode_bubble), 32'd1);
        for (int i = 0; i < 20; i++) idle();
        chk("lit_sat", 32'(bus.o_stall_cycles), 32'd15);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        idle();
        chk("lit_clr", 32'(bus.o_stall_cycles), 32'd0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        idle();

        // Reset in the middle of a wait
        step(1, 0, 1, 5, 0, 0, 0, 0);
        idle();
        chk("lit_mc5_wait", 32'(bus.o_state), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_rst_abort_state", 32'(bus.o_state),    32'd0);
        chk("lit_rst_abort_sh",    32'(bus.o_sys_halt), 32'd0);
        idle();

        // Randomized events
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 15),
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 29) == 0);
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_pipeline_controller.md
SEQ_PIPELINE_CONTROLLER -- requirements
Module: seq_pipeline_controller

Interface
REQ-001 Parameters SHALL be: MC_CNT_WIDTH, default 4, width of multi-cycle length field; STAT_WIDTH, default 16, width of stall statistics counter.
REQ-002 i_clk  in  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 i_halt_instr  in  1  decode stage holds a HALT instruction.
REQ-005 i_resume  in  1  external restart request; honoured only in HALTED.
REQ-006 i_branch_taken  in  1  execute stage resolved a taken branch/jump.
REQ-007 i_mc_start  in  1  multi-cycle operation entering execute this cycle.
REQ-008 i_mc_cycles  in  MC_CNT_WIDTH  total execute cycles of that operation.
REQ-009 i_load_use  in  1  decode operand depends on load currently in execute.
REQ-010 i_clr_stats  in  1  synchronous clear of o_stall_cycles.
REQ-011 o_front_halt  out  1  hold PC and fetch/decode registers.
REQ-012 o_decode_bubble  out  1  decode/execute register loads a NOP.
REQ-013 o_flush  out  1  invalidate fetch and decode registers.
REQ-014 o_sys_halt  out  1  hold execute stage register and all later stages.
REQ-015 o_halted  out  1  controller is in HALTED.
REQ-016 o_state  out  2  current state: RUN=0, MC_WAIT=1, HALTED=2 (3 unused, recovers to RUN).
REQ-017 o_stall_cycles  out  STAT_WIDTH  count of cycles with o_front_halt=1.

Function
REQ-018 State register, down-counter (MC_CNT_WIDTH), pending-halt flag and stats counter SHALL be the only storage; o_front_halt, o_decode_bubble, o_flush, o_sys_halt SHALL be combinational from state and current inputs.
REQ-019 RUN, event priority highest first: i_branch_taken > i_mc_start > i_halt_instr > i_load_use.
REQ-020 RUN, i_branch_taken=1: o_flush=1, all other control outputs 0, state stays RUN; i_mc_start, i_halt_instr, i_load_use ignored.
REQ-021 RUN, i_mc_start=1 and i_mc_cycles>=2: o_front_halt=1; next state MC_WAIT, counter <= i_mc_cycles-2; pending-halt <= i_halt_instr.
REQ-022 RUN, i_mc_start=1 and i_mc_cycles in {0,1}: treated as single-cycle, no state change; lower-priority events evaluated normally.
REQ-023 RUN, i_halt_instr=1 (no higher event): o_front_halt=1, o_decode_bubble=1; next state HALTED.
REQ-024 RUN, only i_load_use=1: o_front_halt=1, o_decode_bubble=1 for exactly that cycle; state stays RUN.
REQ-025 MC_WAIT: o_front_halt=1, o_sys_halt=1, o_decode_bubble=0, o_flush=0; all inputs except i_clr_stats ignored.
REQ-026 MC_WAIT, counter!=0: counter decrements; counter==0: next state HALTED if pending-halt=1, else RUN.
REQ-027 HALTED: o_front_halt=1, o_sys_halt=1, o_halted=1; pending-halt cleared on entry.
REQ-028 HALTED, i_resume=1: next state RUN; first RUN cycle evaluates inputs per REQ-019.
REQ-029 o_stall_cycles SHALL increment by 1 each cycle o_front_halt=1, saturate at all-ones, and i_clr_stats=1 SHALL load 0 (clear wins over increment).
REQ-030 Illegal o_state=3 SHALL return to RUN next cycle with all control outputs 0.

Reset
REQ-031 While i_rst_n=0: state RUN, counter 0, pending-halt 0, o_stall_cycles 0, o_halted 0; combinational outputs follow RUN rules.
REQ-032 Reset asserted in MC_WAIT or HALTED SHALL abort immediately; no pending state survives.

Verification
REQ-033 i_mc_start=1, i_mc_cycles=4 in RUN -> o_front_halt=1 for 4 consecutive cycles, o_sys_halt=1 for the last 3, o_state=1 for 3 cycles then 0.
REQ-034 i_load_use=1 one cycle -> o_front_halt=1, o_decode_bubble=1 that cycle only; o_stall_cycles increments 0->1.
REQ-035 i_branch_taken=1 with i_halt_instr=1 and i_load_use=1 -> o_flush=1, o_front_halt=0, state remains RUN.
REQ-036 i_mc_start=1 (i_mc_cycles=3) with i_halt_instr=1 -> MC_WAIT 2 cycles, then HALTED; i_resume=1 -> RUN next cycle.
REQ-037 i_resume pulsed in RUN and MC_WAIT -> no effect; i_rst_n dropped mid-MC_WAIT -> o_state=0, o_sys_halt=0 immediately.
REQ-038 STAT_WIDTH=4, hold HALTED 20 cycles -> o_stall_cycles=15 saturated; i_clr_stats=1 during stall -> 0.
